// File: rtl/harmonic_accumulator.sv
// Harmonic mixer: walks harmonics 0..N-1, scales each upstream sine sample by a level and sums into a saturated mix.
// Define HARMONIC_ACC_DECAY_EN to make the level decay geometrically by i_Decay after every harmonic.
module harmonic_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int OUT_SHIFT = 4
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Sample_Strobe,
    input  logic [7:0]  i_Harmonic_Count,
    input  logic [7:0]  i_Decay,
    input  logic        i_Sample_Ready,
    input  logic [15:0] i_Sample_Value,
    input  logic        i_Freq_Too_High,
    output logic [7:0]  o_Harmonic,
    output logic        o_Next_Sample,
    output logic [15:0] o_Mix,
    output logic        o_Mix_Valid,
    output logic        o_Busy,
    output logic        o_Overrun,
    output logic [2:0]  o_Debug_State
);

    // Upstream handshake: i_Sample_Ready stays high until o_Next_Sample pulses; the sample and
    // i_Freq_Too_High are trusted only from the second cycle of Ready, and the pulse consumes them.
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_READY = 3'd1,
        S_CAPTURE    = 3'd2,
        S_MULTIPLY   = 3'd3,
        S_ACCUM      = 3'd4,
        S_NEXT       = 3'd5,
        S_OUTPUT     = 3'd6
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] MIX_MAX = ACC_WIDTH'(32767);
    localparam logic signed [ACC_WIDTH-1:0] MIX_MIN = ACC_WIDTH'(-32768);

    state_t                      state;
    state_t                      state_next;
    logic                        start;
    logic [7:0]                  count_q;
    logic signed [15:0]          cap_sample;
    logic                        cap_fth;
    logic signed [16:0]          contrib;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] acc_shifted;
    logic [15:0]                 level;
    logic                        last_harm;
    logic signed [32:0]          product;
    logic [15:0]                 mix_sat;
    logic [8:0]                  harm_plus1;
    logic                        is_last;
    logic                        unused_product_lsbs;

    // Level is treated as unsigned, so it is zero-extended before the signed multiply.
    assign product     = $signed({{17{cap_sample[15]}}, cap_sample}) * $signed({17'd0, level});
    assign acc_shifted = acc >>> OUT_SHIFT;
    assign harm_plus1  = {1'b0, o_Harmonic} + 9'd1;
    assign is_last     = (harm_plus1 >= {1'b0, count_q});
    assign unused_product_lsbs = ^product[15:0];

`ifdef HARMONIC_ACC_DECAY_EN
    logic [7:0]  decay_q;
    logic [23:0] level_prod;
    logic        unused_level_lsbs;
    assign level_prod        = {8'd0, level} * {16'd0, decay_q};
    assign unused_level_lsbs = ^level_prod[7:0];
`else
    logic unused_decay;
    assign unused_decay = ^i_Decay;
`endif

    always_comb begin
        mix_sat = acc_shifted[15:0];
        if (acc_shifted > MIX_MAX) begin
            mix_sat = 16'h7FFF;
        end else if (acc_shifted < MIX_MIN) begin
            mix_sat = 16'h8000;
        end
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (i_Sample_Strobe) begin
                    state_next = (i_Harmonic_Count == 8'd0) ? S_OUTPUT : S_WAIT_READY;
                end
            end
            S_WAIT_READY: if (i_Sample_Ready) state_next = S_CAPTURE;
            S_CAPTURE:    state_next = S_MULTIPLY;
            S_MULTIPLY:   state_next = cap_fth ? S_OUTPUT : S_ACCUM;
            S_ACCUM:      state_next = S_NEXT;
            S_NEXT:       state_next = last_harm ? S_OUTPUT : S_WAIT_READY;
            S_OUTPUT:     state_next = S_IDLE;
            default:      state_next = S_IDLE;
        endcase
    end

    always_comb begin
        start         = 1'b0;
        o_Next_Sample = 1'b0;
        o_Debug_State = state;
        case (state)
            S_IDLE:     start = i_Sample_Strobe;
            S_MULTIPLY: o_Next_Sample = cap_fth;
            S_NEXT:     o_Next_Sample = 1'b1;
            default:    ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            o_Harmonic  <= '0;
            o_Mix       <= '0;
            o_Mix_Valid <= 1'b0;
            o_Busy      <= 1'b0;
            o_Overrun   <= 1'b0;
            count_q     <= '0;
            cap_sample  <= '0;
            cap_fth     <= 1'b0;
            contrib     <= '0;
            acc         <= '0;
            level       <= 16'hFFFF;
            last_harm   <= 1'b0;
`ifdef HARMONIC_ACC_DECAY_EN
            decay_q     <= '0;
`endif
        end else begin
            o_Mix_Valid <= 1'b0;
            // Busy covers OUTPUT too, so a strobe landing there is flagged and dropped.
            if (i_Sample_Strobe && o_Busy) begin
                o_Overrun <= 1'b1;
            end
            if (start) begin
                count_q    <= i_Harmonic_Count;
                acc        <= '0;
                level      <= 16'hFFFF;
                o_Harmonic <= '0;
                o_Busy     <= 1'b1;
`ifdef HARMONIC_ACC_DECAY_EN
                decay_q    <= i_Decay;
`endif
            end
            case (state)
                S_CAPTURE: begin
                    cap_sample <= i_Sample_Value;
                    cap_fth    <= i_Freq_Too_High;
                    // Early termination acknowledges with harmonic 0 so upstream rewinds.
                    if (i_Freq_Too_High) begin
                        o_Harmonic <= '0;
                    end
                end
                S_MULTIPLY: contrib <= product[32:16];
                S_ACCUM: begin
                    acc        <= acc + {{(ACC_WIDTH-17){contrib[16]}}, contrib};
                    last_harm  <= is_last;
                    o_Harmonic <= is_last ? 8'd0 : harm_plus1[7:0];
`ifdef HARMONIC_ACC_DECAY_EN
                    level      <= level_prod[23:8];
`endif
                end
                S_OUTPUT: begin
                    o_Mix       <= mix_sat;
                    o_Mix_Valid <= 1'b1;
                    o_Busy      <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_harmonic_accumulator.sv
// Bench for harmonic_accumulator: randomized upstream responder, arithmetic reference model and directed sweeps.
module tb_harmonic_accumulator;

    localparam int OUT_SHIFT = 4;
`ifdef HARMONIC_ACC_DECAY_EN
    localparam bit DECAY_EN = 1'b1;
`else
    localparam bit DECAY_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_strobe;
    logic [7:0]  harmonic_count;
    logic [7:0]  decay;
    logic        sample_ready;
    logic [15:0] sample_value;
    logic        freq_too_high;
    logic [7:0]  harmonic;
    logic        next_sample;
    logic [15:0] mix;
    logic        mix_valid;
    logic        busy;
    logic        overrun;
    logic [2:0]  debug_state;

    int          total = 0;
    int          bad = 0;
    int          proto_err = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  pulse_q[$];
    logic [15:0] samples[256];
    int          up_fth_idx = -1;

    harmonic_accumulator #(.ACC_WIDTH(24), .OUT_SHIFT(OUT_SHIFT)) dut (
        .i_Clock          (clk),
        .i_Reset          (rst),
        .i_Sample_Strobe  (sample_strobe),
        .i_Harmonic_Count (harmonic_count),
        .i_Decay          (decay),
        .i_Sample_Ready   (sample_ready),
        .i_Sample_Value   (sample_value),
        .i_Freq_Too_High  (freq_too_high),
        .o_Harmonic       (harmonic),
        .o_Next_Sample    (next_sample),
        .o_Mix            (mix),
        .o_Mix_Valid      (mix_valid),
        .o_Busy           (busy),
        .o_Overrun        (overrun),
        .o_Debug_State    (debug_state)
    );

    always #5 clk = ~clk;

    // Upstream responder: Ready rises with junk data, real data from the second Ready cycle,
    // drops Ready the cycle after an acknowledge, then returns after a random gap.
    initial begin : upstream
        bit pending;
        int gap;
        sample_ready  = 1'b0;
        sample_value  = '0;
        freq_too_high = 1'b0;
        pending       = 1'b0;
        gap           = 1;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                sample_ready = 1'b0;
                pending      = 1'b0;
                gap          = 1;
            end else if (pending) begin
                sample_ready  = 1'b0;
                pending       = 1'b0;
                gap           = $urandom_range(0, 2);
                sample_value  = 16'($urandom);
                freq_too_high = 1'($urandom_range(0, 1));
            end else if (sample_ready && next_sample) begin
                pending = 1'b1;
            end else if (!sample_ready) begin
                if (gap == 0) begin
                    sample_ready  = 1'b1;
                    sample_value  = 16'($urandom);
                    freq_too_high = 1'($urandom_range(0, 1));
                end else begin
                    gap = gap - 1;
                end
            end else begin
                sample_value  = samples[harmonic];
                freq_too_high = (int'(harmonic) == up_fth_idx);
            end
        end
    end

    initial begin : pulse_monitor
        logic prev;
        prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (next_sample === 1'b1) begin
                pulse_q.push_back(harmonic);
                if (sample_ready !== 1'b1 || prev) proto_err++;
            end
            prev = (next_sample === 1'b1);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic over the harmonic list, floor-shifted and clamped.
    function automatic logic [15:0] model_mix(input int count, input int dec, input int fth);
        longint acc_m;
        longint level_m;
        longint sh;
        logic [63:0] shv;
        acc_m   = 0;
        level_m = 65535;
        for (int h = 0; h < count; h++) begin
            if (h == fth) break;
            acc_m += (longint'($signed(samples[h])) * level_m) >>> 16;
            level_m = DECAY_EN ? (level_m * dec) / 256 : level_m;
        end
        sh = acc_m >>> OUT_SHIFT;
        if (sh > 32767) sh = 32767;
        else if (sh < -32768) sh = -32768;
        shv = sh;
        return shv[15:0];
    endfunction

    task automatic fill_samples(input bit rand_mode, input logic [15:0] v);
        for (int i = 0; i < 256; i++) samples[i] = rand_mode ? 16'($urandom) : v;
    endtask

    task automatic run_sweep(input int count, input int dec, input int fth,
                             input int overrun_at, input bit check_lat);
        logic [15:0] exp_mix;
        int          n_exp;
        int          base;
        int          cycles;
        bit          done;
        logic [7:0]  eh;
        up_fth_idx = fth;
        repeat (6) @(negedge clk);
        exp_mix = model_mix(count, dec, fth);
        exp_q.push_back(exp_mix);
        base           = pulse_q.size();
        sample_strobe  = 1'b1;
        harmonic_count = 8'(count);
        decay          = 8'(dec);
        @(negedge clk);
        sample_strobe  = 1'b0;
        harmonic_count = 8'($urandom);
        decay          = 8'($urandom);
        cycles = 1;
        done   = 1'b0;
        while (!done && cycles < 6000) begin
            if (mix_valid === 1'b1) begin
                done = 1'b1;
            end else begin
                sample_strobe = (cycles == overrun_at);
                @(negedge clk);
                cycles++;
            end
        end
        sample_strobe = 1'b0;
        check("valid_seen", 32'(done), 32'd1);
        if (!done) begin
            void'(exp_q.pop_front());
        end else begin
            check("mix", 32'(mix), 32'(exp_q.pop_front()));
            check("busy_at_valid", 32'(busy), 32'd0);
            check("harm_idle", 32'(harmonic), 32'd0);
            check("state_idle", 32'(debug_state), 32'd0);
            if (check_lat) check("latency", cycles, (count == 0) ? 2 : 7);
            n_exp = (fth >= 0 && fth < count) ? fth + 1 : count;
            check("pulse_count", pulse_q.size() - base, n_exp);
            for (int i = 0; i < n_exp && (base + i) < pulse_q.size(); i++) begin
                eh = (i == n_exp - 1) ? 8'd0 : 8'(i + 1);
                check("pulse_harm", 32'(pulse_q[base + i]), 32'(eh));
            end
            @(negedge clk);
            check("valid_one_cycle", 32'(mix_valid), 32'd0);
            check("mix_hold", 32'(mix), 32'(exp_mix));
        end
    endtask

    initial begin : main
        int cnt;
        int fth;
        int cyc;
        rst            = 1'b1;
        sample_strobe  = 1'b0;
        harmonic_count = '0;
        decay          = '0;
        fill_samples(1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        check("rst_harmonic", 32'(harmonic), 32'd0);
        check("rst_next", 32'(next_sample), 32'd0);
        check("rst_mix", 32'(mix), 32'd0);
        check("rst_valid", 32'(mix_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_state", 32'(debug_state), 32'd0);
        rst = 1'b0;

        fill_samples(1'b0, 16'h4000);
        run_sweep(1, 255, -1, 0, 1'b1);
        check("single_mix_const", 32'(mix), 32'h03FF);

        fill_samples(1'b0, 16'h7FFF);
        run_sweep(4, 128, -1, 0, 1'b0);

        fill_samples(1'b1, 16'h0000);
        run_sweep(10, 200, 3, 0, 1'b0);

        run_sweep(0, 77, -1, 0, 1'b1);
        check("zero_count_mix", 32'(mix), 32'd0);

        fill_samples(1'b0, 16'h7FFF);
        run_sweep(255, 255, -1, 0, 1'b0);
        check("sat_pos", 32'(mix), 32'h7FFF);
        fill_samples(1'b0, 16'h8000);
        run_sweep(255, 255, -1, 0, 1'b0);
        check("sat_neg", 32'(mix), 32'h8000);

        for (int k = 0; k < 8; k++) begin
            fill_samples(1'b1, 16'h0000);
            cnt = $urandom_range(1, 24);
            fth = ($urandom_range(0, 3) == 0) ? $urandom_range(0, cnt - 1) : -1;
            run_sweep(cnt, $urandom_range(0, 255), fth, 0, 1'b0);
        end

        check("overrun_clear", 32'(overrun), 32'd0);
        fill_samples(1'b1, 16'h0000);
        run_sweep(6, 180, -1, 3, 1'b0);
        check("overrun_set", 32'(overrun), 32'd1);
        fill_samples(1'b1, 16'h0000);
        run_sweep(3, 90, -1, 0, 1'b0);
        check("overrun_sticky", 32'(overrun), 32'd1);

        fill_samples(1'b1, 16'h0000);
        up_fth_idx = -1;
        repeat (6) @(negedge clk);
        sample_strobe  = 1'b1;
        harmonic_count = 8'd10;
        @(negedge clk);
        sample_strobe  = 1'b0;
        cyc = 0;
        while (harmonic !== 8'd5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_h5", 32'(harmonic), 32'd5);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_harm", 32'(harmonic), 32'd0);
        check("midrst_mix", 32'(mix), 32'd0);
        check("midrst_next", 32'(next_sample), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        fill_samples(1'b1, 16'h0000);
        run_sweep(8, 150, -1, 0, 1'b0);

        check("protocol_errs", proto_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
